// File: rtl/sdram_cmd_scheduler_pkg.sv
`default_nettype none
// sdram_pkg: command encodings, FSM states and address field widths shared by
// the SDRAM command scheduler, its interface and its bench. Rev 1.0
package sdram_pkg;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;

  localparam int BANK_W    = 2;
  localparam int ROW_W     = 13;
  localparam int COL_W     = 9;
  localparam int ADDR_W    = BANK_W + ROW_W + COL_W;
  localparam int DATA_W    = 16;
  localparam int SD_ADDR_W = 13;

  typedef enum logic [3:0] {
    ST_WAIT_INIT = 4'd0,
    ST_IDLE      = 4'd1,
    ST_REFRESH   = 4'd2,
    ST_REF_WAIT  = 4'd3,
    ST_ACTIVATE  = 4'd4,
    ST_RCD_WAIT  = 4'd5,
    ST_WRITE     = 4'd6,
    ST_READ      = 4'd7,
    ST_CAS_WAIT  = 4'd8,
    ST_WR_WAIT   = 4'd9,
    ST_PRECHARGE = 4'd10,
    ST_RP_WAIT   = 4'd11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sdram_cmd_scheduler_if.sv
`default_nettype none
// sdram_cmd_scheduler_if: request/response handshake plus SDRAM pin bundle.
// Rev 1.0
interface sdram_cmd_scheduler_if import sdram_pkg::*; ();

  logic                 iinit_done;
  logic                 ireq_wr;
  logic                 ireq_rd;
  logic [ADDR_W-1:0]    iaddr;
  logic [DATA_W-1:0]    iwdata;
  logic                 oack;
  logic [DATA_W-1:0]    ordata;
  logic                 ordvalid;
  logic                 obusy;
  logic [3:0]           ocmd;
  logic [SD_ADDR_W-1:0] oaddr;
  logic [BANK_W-1:0]    oba;
  logic [1:0]           odqm;
  logic [DATA_W-1:0]    odq_out;
  logic                 odq_oe;
  logic [DATA_W-1:0]    idq_in;

  modport master (
    output iinit_done, ireq_wr, ireq_rd, iaddr, iwdata, idq_in,
    input  oack, ordata, ordvalid, obusy, ocmd, oaddr, oba, odqm, odq_out, odq_oe
  );

  modport slave (
    input  iinit_done, ireq_wr, ireq_rd, iaddr, iwdata, idq_in,
    output oack, ordata, ordvalid, obusy, ocmd, oaddr, oba, odqm, odq_out, odq_oe
  );

endinterface
`default_nettype wire

// File: rtl/sdram_cmd_scheduler_refresh_timer.sv
`default_nettype none
// sdram_refresh_timer: free-running interval counter raising a sticky refresh
// request that holds until the scheduler services it. Rev 1.0
module sdram_refresh_timer #(
  parameter int INTERVAL = 780
) (
  input  logic iclk,
  input  logic ctr_reset,
  input  logic en,
  input  logic clr_pending,
  output logic pending
);

  localparam int CNT_W = $clog2(INTERVAL);

  logic [CNT_W-1:0] count;
  logic             expire;

  assign expire = en && (count == CNT_W'(INTERVAL - 1));

  // An expiry coinciding with a clear wins, so no interval is ever lost.
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      count   <= '0;
      pending <= 1'b0;
    end else begin
      if (en) count <= expire ? '0 : count + 1'b1;
      if (expire)           pending <= 1'b1;
      else if (clr_pending) pending <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_cmd_scheduler.sv
`default_nettype none
// sdram_cmd_scheduler: post-init SDRAM command scheduler arbitrating single-word
// reads/writes against auto-refresh, all outputs registered. Rev 1.0
module sdram_cmd_scheduler import sdram_pkg::*; #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int T_RCD            = 2,
  parameter int T_RP             = 2,
  parameter int T_RC             = 7,
  parameter int T_WR             = 2,
  parameter int CAS_LAT          = 2
) (
  input  logic                 iclk,
  input  logic                 ctr_reset,
  sdram_cmd_scheduler_if.slave bus
);

  localparam int WAIT_W = 8;

  state_t               state, state_nxt;
  logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
  logic                 wait_done;
  logic                 accept;
  logic                 ref_pending;

  logic [ADDR_W-1:0]    lat_addr;
  logic                 lat_wr;
  logic [DATA_W-1:0]    lat_data;

  logic [3:0]           cmd, cmd_nxt;
  logic [SD_ADDR_W-1:0] sd_addr, sd_addr_nxt;
  logic [BANK_W-1:0]    ba, ba_nxt;
  logic [1:0]           dqm, dqm_nxt;
  logic [DATA_W-1:0]    dq_out, dq_out_nxt;
  logic                 dq_oe, dq_oe_nxt;
  logic                 ack, ack_nxt;
  logic [DATA_W-1:0]    rdata, rdata_nxt;
  logic                 rdvalid, rdvalid_nxt;
  logic                 busy, busy_nxt;

  logic [BANK_W-1:0]    lat_bank;
  logic [ROW_W-1:0]     lat_row;
  logic [COL_W-1:0]     lat_col;

  assign lat_bank  = lat_addr[ADDR_W-1 -: BANK_W];
  assign lat_row   = lat_addr[COL_W +: ROW_W];
  assign lat_col   = lat_addr[COL_W-1:0];
  assign wait_done = (wait_cnt == '0);

  sdram_refresh_timer #(
    .INTERVAL (REFRESH_INTERVAL)
  ) u_refresh_timer (
    .iclk        (iclk),
    .ctr_reset   (ctr_reset),
    .en          (bus.iinit_done),
    .clr_pending (state == ST_REFRESH),
    .pending     (ref_pending)
  );

  // Bus outputs are decoded from the current state and registered, so each
  // command appears on the pins one cycle after its state is entered.
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    accept      = 1'b0;
    cmd_nxt     = CMD_NOP;
    sd_addr_nxt = sd_addr;
    ba_nxt      = ba;
    dqm_nxt     = 2'b11;
    dq_out_nxt  = dq_out;
    dq_oe_nxt   = 1'b0;
    rdata_nxt   = rdata;
    rdvalid_nxt = 1'b0;

    case (state)
      ST_WAIT_INIT: if (bus.iinit_done) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (ref_pending) begin
          state_nxt = ST_REFRESH;
        end else if (bus.ireq_wr || bus.ireq_rd) begin
          state_nxt = ST_ACTIVATE;
          accept    = 1'b1;
        end
      end
      ST_REFRESH: begin
        cmd_nxt   = CMD_REFRESH;
        state_nxt = ST_REF_WAIT;
        wait_nxt  = WAIT_W'(T_RC - 2);
      end
      ST_REF_WAIT: begin
        if (wait_done) state_nxt = ST_IDLE;
        else           wait_nxt  = wait_cnt - 1'b1;
      end
      ST_ACTIVATE: begin
        cmd_nxt     = CMD_ACTIVE;
        ba_nxt      = lat_bank;
        sd_addr_nxt = lat_row;
        state_nxt   = ST_RCD_WAIT;
        wait_nxt    = WAIT_W'(T_RCD - 2);
      end
      ST_RCD_WAIT: begin
        if (wait_done) state_nxt = lat_wr ? ST_WRITE : ST_READ;
        else           wait_nxt  = wait_cnt - 1'b1;
      end
      ST_WRITE: begin
        cmd_nxt     = CMD_WRITE;
        sd_addr_nxt = {4'b0000, lat_col};
        dq_out_nxt  = lat_data;
        dq_oe_nxt   = 1'b1;
        dqm_nxt     = 2'b00;
        state_nxt   = ST_WR_WAIT;
        wait_nxt    = WAIT_W'(T_WR - 1);
      end
      ST_WR_WAIT: begin
        if (wait_done) state_nxt = ST_PRECHARGE;
        else           wait_nxt  = wait_cnt - 1'b1;
      end
      ST_READ: begin
        cmd_nxt     = CMD_READ;
        sd_addr_nxt = {4'b0000, lat_col};
        dqm_nxt     = 2'b00;
        state_nxt   = ST_CAS_WAIT;
        wait_nxt    = WAIT_W'(CAS_LAT);
      end
      ST_CAS_WAIT: begin
        // Last wait cycle lines up with DQ valid CAS_LAT cycles after READ.
        dqm_nxt = 2'b00;
        if (wait_done) begin
          rdata_nxt   = bus.idq_in;
          rdvalid_nxt = 1'b1;
          state_nxt   = ST_PRECHARGE;
        end else begin
          wait_nxt = wait_cnt - 1'b1;
        end
      end
      ST_PRECHARGE: begin
        cmd_nxt     = CMD_PRECHARGE;
        sd_addr_nxt = 13'h0400;
        state_nxt   = ST_RP_WAIT;
        wait_nxt    = WAIT_W'(T_RP - 2);
      end
      ST_RP_WAIT: begin
        if (wait_done) state_nxt = ST_IDLE;
        else           wait_nxt  = wait_cnt - 1'b1;
      end
      default: state_nxt = ST_WAIT_INIT;
    endcase

    ack_nxt  = accept;
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state    <= ST_WAIT_INIT;
      wait_cnt <= '0;
      lat_addr <= '0;
      lat_wr   <= 1'b0;
      lat_data <= '0;
      cmd      <= CMD_NOP;
      sd_addr  <= '0;
      ba       <= '0;
      dqm      <= 2'b11;
      dq_out   <= '0;
      dq_oe    <= 1'b0;
      ack      <= 1'b0;
      rdata    <= '0;
      rdvalid  <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (accept) begin
        lat_addr <= bus.iaddr;
        lat_wr   <= bus.ireq_wr;
        lat_data <= bus.iwdata;
      end
      cmd      <= cmd_nxt;
      sd_addr  <= sd_addr_nxt;
      ba       <= ba_nxt;
      dqm      <= dqm_nxt;
      dq_out   <= dq_out_nxt;
      dq_oe    <= dq_oe_nxt;
      ack      <= ack_nxt;
      rdata    <= rdata_nxt;
      rdvalid  <= rdvalid_nxt;
      busy     <= busy_nxt;
    end
  end

  assign bus.ocmd     = cmd;
  assign bus.oaddr    = sd_addr;
  assign bus.oba      = ba;
  assign bus.odqm     = dqm;
  assign bus.odq_out  = dq_out;
  assign bus.odq_oe   = dq_oe;
  assign bus.oack     = ack;
  assign bus.ordata   = rdata;
  assign bus.ordvalid = rdvalid;
  assign bus.obusy    = busy;

endmodule
`default_nettype wire
